// File: rtl/gorilla_pc_pkg.sv
// Shared definitions for Gorilla++ engines on the performance-counter ring:
// field widths, ring opcodes, counter port IDs and the per-thread state type.
package gorilla_pc_pkg;

    localparam int unsigned PC_MODULE_ID_W = 16;
    localparam int unsigned PC_PORT_ID_W   = 8;
    localparam int unsigned PC_TYPE_W      = 4;

    localparam logic [PC_TYPE_W-1:0]      PC_CLEAR        = 4'd2;
    localparam logic [PC_MODULE_ID_W-1:0] PC_BROADCAST_ID = 16'hFFFF;

    localparam int unsigned PC_IN_STALL  = 0;
    localparam int unsigned PC_OUT_STALL = 1;
    localparam int unsigned PC_ACCEPT    = 2;
    localparam int unsigned PC_EMIT      = 3;
    localparam int unsigned PC_NUM_CNT   = 4;

    typedef enum logic [1:0] {
        ThrIdle,
        ThrBusy,
        ThrEmit
    } thr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer; the pointer
// moves to the slot after the granted one only when advance_i is strobed.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    req_i,
    input  logic            advance_i,
    output logic            valid_o,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] gnt_idx_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        valid_o   = 1'b0;
        cand      = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = IdxW'((32'(ptr_q) + off) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && valid_o) begin
            ptr_d = (gnt_idx_o == IdxW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/send_const_mt.sv
// Multi-threaded constant-response engine: each accepted tag is answered with CONST_VAL
// from one of NUM_THREADS contexts; four saturating counters are served on the pc ring.
module send_const_mt
    import gorilla_pc_pkg::*;
#(
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned CONST_VAL   = 2,
    parameter int unsigned MODULE_ID   = 5,
    parameter int unsigned PC_W        = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      io_in_valid,
    output logic                      io_in_ready,
    input  logic [DATA_W-1:0]         io_in_bits,
    input  logic [TAG_W-1:0]          io_in_tag,
    output logic                      io_out_valid,
    input  logic                      io_out_ready,
    output logic [DATA_W-1:0]         io_out_bits,
    output logic [TAG_W-1:0]          io_out_tag,
    input  logic                      io_pcIn_valid,
    input  logic                      io_pcIn_bits_request,
    input  logic [PC_MODULE_ID_W-1:0] io_pcIn_bits_moduleId,
    input  logic [PC_PORT_ID_W-1:0]   io_pcIn_bits_portId,
    input  logic [PC_W-1:0]           io_pcIn_bits_pcValue,
    input  logic [PC_TYPE_W-1:0]      io_pcIn_bits_pcType,
    output logic                      io_pcOut_valid,
    output logic                      io_pcOut_bits_request,
    output logic [PC_MODULE_ID_W-1:0] io_pcOut_bits_moduleId,
    output logic [PC_PORT_ID_W-1:0]   io_pcOut_bits_portId,
    output logic [PC_W-1:0]           io_pcOut_bits_pcValue,
    output logic [PC_TYPE_W-1:0]      io_pcOut_bits_pcType
);

    localparam int unsigned IdxW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam logic [PC_MODULE_ID_W-1:0] ModId = PC_MODULE_ID_W'(MODULE_ID);

    thr_state_e       state_q [NUM_THREADS];
    thr_state_e       state_d [NUM_THREADS];
    logic [TAG_W-1:0] tag_q   [NUM_THREADS];
    logic [TAG_W-1:0] tag_d   [NUM_THREADS];
    logic             lock_q, lock_d;
    logic [IdxW-1:0]  lock_idx_q, lock_idx_d;

    logic [NUM_THREADS-1:0] idle_vec, emit_req, acc_gnt, emit_gnt;
    logic [IdxW-1:0]        emit_idx, unused_acc_idx;
    logic                   acc_valid, emit_valid, acc_fire, out_fire;
    logic                   unused_in_bits;

    assign unused_in_bits = ^io_in_bits;

    // While stalled the emit arbiter only sees the presented thread, so tag stays stable.
    always_comb begin
        idle_vec = '0;
        emit_req = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            idle_vec[i] = (state_q[i] == ThrIdle);
            emit_req[i] = lock_q ? (lock_idx_q == IdxW'(i)) : (state_q[i] == ThrEmit);
        end
    end

    rr_arbiter #(.N(NUM_THREADS)) u_acc_arb (
        .clk_i     (clk),
        .rst_ni    (reset),
        .req_i     (idle_vec),
        .advance_i (acc_fire),
        .valid_o   (acc_valid),
        .gnt_o     (acc_gnt),
        .gnt_idx_o (unused_acc_idx)
    );

    rr_arbiter #(.N(NUM_THREADS)) u_emit_arb (
        .clk_i     (clk),
        .rst_ni    (reset),
        .req_i     (emit_req),
        .advance_i (out_fire),
        .valid_o   (emit_valid),
        .gnt_o     (emit_gnt),
        .gnt_idx_o (emit_idx)
    );

    assign io_in_ready  = acc_valid;
    assign acc_fire     = io_in_valid && acc_valid;
    assign io_out_valid = emit_valid;
    assign out_fire     = emit_valid && io_out_ready;
    assign io_out_bits  = emit_valid ? DATA_W'(CONST_VAL) : '0;
    assign io_out_tag   = emit_valid ? tag_q[emit_idx] : '0;
    assign lock_d       = emit_valid && !io_out_ready;
    assign lock_idx_d   = emit_idx;

    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            state_d[i] = state_q[i];
            tag_d[i]   = tag_q[i];
            case (state_q[i])
                ThrIdle: begin
                    if (acc_fire && acc_gnt[i]) begin
                        state_d[i] = ThrBusy;
                        tag_d[i]   = io_in_tag;
                    end
                end
                ThrBusy: state_d[i] = ThrEmit;
                ThrEmit: begin
                    if (out_fire && emit_gnt[i]) state_d[i] = ThrIdle;
                end
                default: state_d[i] = ThrIdle;
            endcase
        end
    end

    logic [PC_W-1:0]       cnt_q [PC_NUM_CNT];
    logic [PC_W-1:0]       cnt_d [PC_NUM_CNT];
    logic [PC_NUM_CNT-1:0] cnt_inc;
    logic                  pc_clear, pc_hit;
    logic [PC_W-1:0]       rd_value;

    assign cnt_inc[PC_IN_STALL]  = io_in_valid && !acc_valid;
    assign cnt_inc[PC_OUT_STALL] = emit_valid && !io_out_ready;
    assign cnt_inc[PC_ACCEPT]    = acc_fire;
    assign cnt_inc[PC_EMIT]      = out_fire;

    assign pc_hit   = io_pcIn_valid && io_pcIn_bits_request && (io_pcIn_bits_moduleId == ModId);
    assign pc_clear = io_pcIn_valid && io_pcIn_bits_request &&
                      (io_pcIn_bits_pcType == PC_CLEAR) &&
                      ((io_pcIn_bits_moduleId == ModId) ||
                       (io_pcIn_bits_moduleId == PC_BROADCAST_ID));

    always_comb begin
        for (int i = 0; i < PC_NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (pc_clear) begin
                cnt_d[i] = '0;
            end else if (cnt_inc[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rd_value = '0;
        if (io_pcIn_bits_portId < PC_PORT_ID_W'(PC_NUM_CNT)) begin
            rd_value = cnt_q[io_pcIn_bits_portId[1:0]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                state_q[i] <= ThrIdle;
                tag_q[i]   <= '0;
            end
            for (int i = 0; i < PC_NUM_CNT; i++) cnt_q[i] <= '0;
            lock_q                 <= 1'b0;
            lock_idx_q             <= '0;
            io_pcOut_valid         <= 1'b0;
            io_pcOut_bits_request  <= 1'b1;
            io_pcOut_bits_moduleId <= '0;
            io_pcOut_bits_portId   <= '0;
            io_pcOut_bits_pcValue  <= '0;
            io_pcOut_bits_pcType   <= '0;
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                state_q[i] <= state_d[i];
                tag_q[i]   <= tag_d[i];
            end
            for (int i = 0; i < PC_NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
            lock_q                 <= lock_d;
            lock_idx_q             <= lock_idx_d;
            io_pcOut_valid         <= pc_hit ? 1'b1 : io_pcIn_valid;
            io_pcOut_bits_request  <= pc_hit ? 1'b0 : io_pcIn_bits_request;
            io_pcOut_bits_moduleId <= io_pcIn_bits_moduleId;
            io_pcOut_bits_portId   <= io_pcIn_bits_portId;
            io_pcOut_bits_pcValue  <= pc_hit ? rd_value : io_pcIn_bits_pcValue;
            io_pcOut_bits_pcType   <= io_pcIn_bits_pcType;
        end
    end

endmodule
